// File: rtl/bpu_pkg.sv
// Shared definitions for the gshare branch predictor: opcodes, link-register
// detection, saturating counter helpers and RAS operation encoding.
package bpu_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } ras_op_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Counters are passed zero-extended to 32 bits; w is the live counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input int unsigned w);
    logic [31:0] max;
    max = (32'd1 << w) - 32'd1;
    return (c == max) ? c : c + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] c, input int unsigned w);
    logic [31:0] unused_w;
    unused_w = 32'(w);
    return (c == 32'd0) ? c : c - 32'd1;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Return-address stack: ring buffer with saturating occupancy count; a push
// into a full stack silently overwrites the oldest entry.
module bpu_ras
  import bpu_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  ras_op_e       op_i,
  input  logic [AW-1:0] push_addr_i,
  output logic [AW-1:0] top_o,
  output logic          empty_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [AW-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   count;
  logic [PW-1:0] top_idx;

  assign top_idx = ptr - PW'(1);
  assign top_o   = stack[top_idx];
  assign empty_o = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else begin
      case (op_i)
        RAS_PUSH: begin
          stack[ptr] <= push_addr_i;
          ptr        <= ptr + PW'(1);
          if (count != FULL) count <= count + (PW+1)'(1);
        end
        RAS_POP: begin
          if (count != '0) begin
            ptr   <= top_idx;
            count <= count - (PW+1)'(1);
          end
        end
        RAS_POPPUSH: begin
          // Pop followed by push collapses to replacing the top in place.
          if (count != '0) begin
            stack[top_idx] <= push_addr_i;
          end else begin
            stack[ptr] <= push_addr_i;
            ptr        <= ptr + PW'(1);
            count      <= count + (PW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gshare_bpu.sv
// IF-stage gshare branch predictor with speculative global history, EXU-side
// training/repair and a return-address stack for JALR returns.
module gshare_bpu
  import bpu_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_i,
  input  logic             inst_valid_i,
  input  logic [AW-1:0]    pc_i,
  input  logic             any_stall_i,
  output logic             branch_taken_o,
  output logic [AW-1:0]    branch_addr_o,
  output logic             is_pred_branch_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             update_valid_i,
  input  logic [AW-1:0]    update_pc_i,
  input  logic [GHR_W-1:0] update_ghr_i,
  input  logic             real_taken_i,
  input  logic             mispredict_i
);

  localparam int unsigned PHT_N = 1 << PHT_IDX_W;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1;
  logic        is_br, is_jal, is_jalr, rd_link, rs1_link, is_ret, fire;
  logic [31:0] imm_b, imm_j;
  logic [AW-1:0] pc_plus4, br_tgt, jal_tgt, target, ras_top;
  logic        taken, ras_empty;
  ras_op_e     ras_op;

  logic [GHR_W-1:0]     ghr;
  logic [CNT_W-1:0]     pht [PHT_N];
  logic [PHT_IDX_W-1:0] ridx, widx;
  logic                 unused_upd;

  assign opcode   = inst_i[6:0];
  assign rd       = inst_i[11:7];
  assign rs1      = inst_i[19:15];
  assign is_br    = (opcode == OPC_BRANCH);
  assign is_jal   = (opcode == OPC_JAL);
  assign is_jalr  = (opcode == OPC_JALR);
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);
  assign is_ret   = is_jalr & rs1_link & (rd != rs1);
  assign fire     = inst_valid_i & ~any_stall_i;

  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  assign pc_plus4 = pc_i + AW'(4);
  assign br_tgt   = pc_i + AW'(imm_b);
  assign jal_tgt  = pc_i + AW'(imm_j);

  assign ridx = pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign widx = update_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(update_ghr_i);
  assign unused_upd = ^{update_pc_i[AW-1:PHT_IDX_W+2], update_pc_i[1:0]};

  always_comb begin
    taken  = 1'b0;
    target = pc_plus4;
    ras_op = RAS_NONE;
    if (is_br) begin
      taken  = pht[ridx][CNT_W-1];
      target = br_tgt;
    end else if (is_jal) begin
      taken  = 1'b1;
      target = jal_tgt;
    end else if (is_ret) begin
      taken  = ~ras_empty;
      target = ras_top;
    end

    if (is_jal && rd_link) begin
      ras_op = RAS_PUSH;
    end else if (is_jalr) begin
      if (rd_link && rs1_link) ras_op = (rd == rs1) ? RAS_PUSH : RAS_POPPUSH;
      else if (rd_link)        ras_op = RAS_PUSH;
      else if (rs1_link)       ras_op = RAS_POP;
    end
    if (!fire) ras_op = RAS_NONE;
  end

  assign branch_taken_o   = taken & fire;
  assign branch_addr_o    = (inst_valid_i && taken) ? target : pc_plus4;
  assign is_pred_branch_o = fire & is_br & taken;
  assign pred_ghr_o       = inst_valid_i ? ghr : '0;

  // Repair from EXU wins over a same-cycle speculative shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (update_valid_i && mispredict_i) begin
      ghr <= GHR_W'({update_ghr_i, real_taken_i});
    end else if (fire && is_br) begin
      ghr <= GHR_W'({ghr, taken});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= CNT_RST;
    end else if (update_valid_i) begin
      pht[widx] <= real_taken_i ? CNT_W'(sat_inc(32'(pht[widx]), CNT_W))
                                : CNT_W'(sat_dec(32'(pht[widx]), CNT_W));
    end
  end

  bpu_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .AW        (AW)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_i        (ras_op),
    .push_addr_i (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

endmodule
